// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the sccomp data memory between the CPU port and a debug/loader port.
// Build option ARB_PERF_EN adds the cpu_wait_cnt / dbg_gnt_cnt performance counters.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_wstrb,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_wstrb,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   dbg_rdata,
  input  logic            dbg_lock,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]     cpu_wait_cnt,
  output logic [31:0]     dbg_gnt_cnt
`endif
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {ARB_CPU, ARB_DBG, ARB_LOCK} arb_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_DBG} rd_tag_t;

  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mem_cmd_t;

  arb_state_t    state;
  rd_tag_t       rd_tag;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_nxt;
  logic          lock_inc;
  logic          force_break;
  mem_cmd_t      cmd;

  // Grants are combinational so the CPU sees the stall in the same cycle it asks.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (state == ARB_CPU) begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req && !cpu_req;
      end else begin
        dbg_gnt = dbg_req;
        cpu_gnt = cpu_req && !dbg_req;
      end
    end
  end

  always_comb begin
    cmd = '0;
    if (cpu_gnt) begin
      cmd.en    = 1'b1;
      cmd.we    = cpu_we;
      cmd.addr  = cpu_addr;
      cmd.wdata = cpu_wdata;
      cmd.wstrb = cpu_we ? cpu_wstrb : '0;
    end else if (dbg_gnt) begin
      cmd.en    = 1'b1;
      cmd.we    = dbg_we;
      cmd.addr  = dbg_addr;
      cmd.wdata = dbg_wdata;
      cmd.wstrb = dbg_we ? dbg_wstrb : '0;
    end
  end

  assign mem_en    = cmd.en;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign mem_wstrb = cmd.wstrb;

  // The cycle the counter reaches MAX_LOCK is the last dbg grant before the CPU is let in.
  assign lock_inc     = (state == ARB_LOCK) && cpu_req && !cpu_gnt;
  assign lock_cnt_nxt = (lock_inc && lock_cnt != CW'(MAX_LOCK)) ? lock_cnt + 1'b1 : lock_cnt;
  assign force_break  = lock_inc && (lock_cnt_nxt == CW'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_CPU;
      lock_cnt <= '0;
      rd_tag   <= TAG_NONE;
    end else begin
      if (cpu_gnt && !cpu_we)      rd_tag <= TAG_CPU;
      else if (dbg_gnt && !dbg_we) rd_tag <= TAG_DBG;
      else                         rd_tag <= TAG_NONE;

      case (state)
        ARB_CPU: begin
          if (cpu_gnt)      state <= ARB_DBG;
          else if (dbg_gnt) state <= dbg_lock ? ARB_LOCK : ARB_CPU;
        end
        ARB_DBG: begin
          if (dbg_gnt)      state <= dbg_lock ? ARB_LOCK : ARB_CPU;
          else if (cpu_gnt) state <= ARB_DBG;
        end
        ARB_LOCK: begin
          if (!dbg_lock || force_break) begin
            state    <= ARB_CPU;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt_nxt;
          end
        end
        default: state <= ARB_CPU;
      endcase
    end
  end

  assign cpu_rvalid = !rst && (rd_tag == TAG_CPU);
  assign dbg_rvalid = !rst && (rd_tag == TAG_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_wait_cnt <= '0;
      dbg_gnt_cnt  <= '0;
    end else begin
      if (cpu_req && !cpu_gnt) cpu_wait_cnt <= cpu_wait_cnt + 32'd1;
      if (dbg_gnt)             dbg_gnt_cnt  <= dbg_gnt_cnt + 32'd1;
    end
  end
`endif

endmodule
